// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer -- output stage of the ALU datapath.
// Shifts one ALU response out on sout as 11-bit packets:
// start 0, type (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop 1.
// A normal response is DATA_BYTES DATA packets of C (MSB byte first) and
// then one CMD packet {0, flags, crc}. An error response is one CMD packet
// that carries in_ctl unchanged.
// Optional macro MTM_SER_CRC_GEN_EN: when defined, crc[2:0] is a CRC-3
// (x^3+x+1, init 0) over {C, 1'b0, flags}. When undefined, crc[2:0] is the
// captured in_ctl[2:0].
module mtm_alu_serializer #(
    parameter int DATA_BYTES = 4,
    parameter int IDLE_GAP   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_err,
    input  logic [31:0] in_c,
    input  logic [3:0]  in_flags,
    input  logic [7:0]  in_ctl,
    output logic        sout,
    output logic        busy
);

    localparam int PW = $clog2(DATA_BYTES + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [PW-1:0] LAST_PKT = PW'(DATA_BYTES);
    localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_TYPE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_STOP    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t          state_r;
    logic [2:0]      bit_cnt_r;
    logic [PW-1:0]   pkt_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [31:0]     c_r;
    logic [3:0]      flags_r;
    logic [7:0]      ctl_r;
    logic            err_r;
    logic            sout_r;
    logic            busy_r;
    logic            in_ready_r;

    logic [2:0]      crc_s;
    logic            type_s;
    logic [7:0]      cur_byte_s;

    // Select the data byte for packet idx. Packet 0 carries the most
    // significant byte of C.
    function automatic logic [7:0] data_byte(input logic [31:0] c, input logic [PW-1:0] idx);
        int          sel;
        logic [31:0] sh;
        sel = DATA_BYTES - 1 - int'(idx);
        sel = (sel < 0) ? 0 : sel;
        sh  = c >> (8 * sel);
        return sh[7:0];
    endfunction

`ifdef MTM_SER_CRC_GEN_EN
    // Serial CRC-3 over the frame's data bits, x^3+x+1, MSB first, init 0.
    function automatic logic [2:0] crc3_calc(input logic [36:0] d);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ d[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction
`endif

    // Payload byte of the packet currently selected by the packet counter.
    always_comb begin
`ifdef MTM_SER_CRC_GEN_EN
        crc_s = crc3_calc({c_r, 1'b0, flags_r});
`else
        crc_s = ctl_r[2:0];
`endif
        type_s     = (pkt_cnt_r == LAST_PKT);
        cur_byte_s = 8'h00;
        if (type_s) begin
            if (err_r) begin
                cur_byte_s = ctl_r;
            end else begin
                cur_byte_s = {1'b0, flags_r, crc_s};
            end
        end else begin
            cur_byte_s = data_byte(c_r, pkt_cnt_r);
        end
    end

    // Packet framing state machine. Outputs are registered and are set
    // for the state being entered, so sout follows the state with no
    // extra pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            pkt_cnt_r  <= {PW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            c_r        <= 32'h0000_0000;
            flags_r    <= 4'h0;
            ctl_r      <= 8'h00;
            err_r      <= 1'b0;
            sout_r     <= 1'b1;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        c_r        <= in_c;
                        flags_r    <= in_flags;
                        ctl_r      <= in_ctl;
                        err_r      <= in_err;
                        // An error response is just the final CMD packet.
                        pkt_cnt_r  <= in_err ? LAST_PKT : {PW{1'b0}};
                        state_r    <= ST_START;
                        sout_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                    end else begin
                        sout_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_START: begin
                    state_r <= ST_TYPE;
                    sout_r  <= type_s;
                end
                ST_TYPE: begin
                    state_r   <= ST_PAYLOAD;
                    bit_cnt_r <= 3'd7;
                    sout_r    <= cur_byte_s[7];
                end
                ST_PAYLOAD: begin
                    if (bit_cnt_r == 3'd0) begin
                        state_r <= ST_STOP;
                        sout_r  <= 1'b1;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 3'd1;
                        sout_r    <= cur_byte_s[bit_cnt_r - 3'd1];
                    end
                end
                ST_STOP: begin
                    if (type_s) begin
                        state_r    <= ST_IDLE;
                        sout_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                    end else begin
                        pkt_cnt_r <= pkt_cnt_r + {{(PW-1){1'b0}}, 1'b1};
                        if (IDLE_GAP > 0) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= GAP_LOAD;
                            sout_r    <= 1'b1;
                        end else begin
                            state_r <= ST_START;
                            sout_r  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == {GW{1'b0}}) begin
                        state_r <= ST_START;
                        sout_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - {{(GW-1){1'b0}}, 1'b1};
                        sout_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sout_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign sout     = sout_r;
    assign busy     = busy_r;
    assign in_ready = in_ready_r;

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
- Output stage of the ALU datapath. Takes one ALU response (32-bit result C plus control byte, or an error control byte) and shifts it out serially on sout, using the same packet format the input deserializer accepts.
- Sits downstream of the ALU core, which itself sits downstream of the deserializer.
- sout idles high. Each packet is 11 bits: start 0, type bit (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop 1.

Parameters:
- DATA_BYTES, 4, number of DATA packets in a normal response (C sent MSB byte first).
- IDLE_GAP, 0, number of idle-high cycles inserted between consecutive packets of one response.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  response available from ALU core.
- in_ready  output  1  serializer can accept a response this cycle.
- in_err  input  1  1 = error response (single CMD packet only).
- in_c  input  32  ALU result C; ignored when in_err=1.
- in_flags  input  4  ALU flags {carry, overflow, zero, negative}; ignored when in_err=1.
- in_ctl  input  8  control byte: supplied CRC bits [2:0] for normal responses, or full error byte when in_err=1.
- sout  output  1  serial output, idle high.
- busy  output  1  high while a response is being transmitted.

Behaviour:
- Reset (rst sampled high at posedge):
  - sout=1, in_ready=1, busy=0.
  - State=IDLE; bit and packet counters cleared; holding registers cleared.
  - Reset mid-frame aborts the frame immediately: sout=1 from the next cycle, no partial stop bit.
- Handshake:
  - Transfer occurs on a posedge where in_valid && in_ready.
  - in_ready = (state==IDLE); it drops the cycle after acceptance.
  - in_c, in_flags, in_ctl and in_err are captured into holding registers at the transfer.
  - Inputs are don't-care outside the transfer cycle.
  - in_valid held high while busy has no effect.
- Latency: the start bit appears on sout in the cycle after the transfer edge. busy rises with the start bit.
- Normal response (in_err=0):
  - DATA_BYTES DATA packets: C[31:24], C[23:16], C[15:8], C[7:0].
  - Then one CMD packet with payload {1'b0, flags[3:0], crc[2:0]}.
  - With defaults: 55 bit-cycles of frame.
- Error response (in_err=1): one CMD packet, payload = in_ctl verbatim. 11 bit-cycles.
- State machine:
  - IDLE -> START on transfer.
  - START (sout=0, 1 cycle) -> TYPE.
  - TYPE (sout=type, 1 cycle) -> PAYLOAD.
  - PAYLOAD (8 cycles, MSB first, 3-bit counter 7..0) -> STOP.
  - STOP (sout=1, 1 cycle) -> GAP if IDLE_GAP>0 and more packets remain; else START if more packets remain; else IDLE.
  - GAP (sout=1, IDLE_GAP cycles) -> START.
- Packet counter counts 0..DATA_BYTES. The CMD packet is the last; no wrap beyond it.
- Back-to-back responses:
  - IDLE is entered the cycle after the last stop bit, with in_ready=1 in that cycle.
  - A transfer then gives a start bit one cycle later, so there is a minimum of one idle-high bit between responses.
- busy falls in the same cycle in_ready rises.
- Simultaneous rst and in_valid: reset wins; no capture.

Optional Feature:
- Macro: MTM_SER_CRC_GEN_EN.
- Defined:
  - crc[2:0] is generated internally as CRC-3, polynomial x^3+x+1, init 3'b000.
  - CRC is computed over the 37-bit sequence {C[31:0], 1'b0, flags[3:0]}, C[31] first.
  - It is computed combinationally from the holding registers and used in the CMD payload.
  - in_ctl[2:0] is ignored for normal responses.
- Undefined: crc[2:0] = captured in_ctl[2:0] (the ALU core supplies the CRC).
- The error-response path is unaffected in both builds.

Test Plan:
- Reset: assert rst mid-PAYLOAD of packet 2 -> next cycle sout=1, in_ready=1, busy=0. A new transfer afterwards produces a clean frame.
- Normal, macro undefined: C=32'h12345678, flags=4'b0010, in_ctl=8'h05 -> 55-bit sout stream:
  - 0 0 00010010 1, 0 0 00110100 1, 0 0 01010110 1, 0 0 01111000 1.
  - Then 0 1 00010101 1.
  - Then sout=1 and in_ready=1.
- Error response: in_err=1, in_ctl=8'b11001001 -> exactly 0 1 11001001 1, then idle. Total busy = 11 cycles.
- Macro defined: C=32'hFFFFFFFF, flags=4'b1000, in_ctl[2:0]=3'b111 -> CMD payload bits [2:0] equal the bench CRC-3 model over {C,0,flags}, independent of in_ctl.
- Back-to-back: in_valid held high for two responses -> second start bit exactly 2 cycles after the first frame's last stop bit. in_ready is high for exactly 1 cycle between the frames.
- IDLE_GAP=2: normal response -> two sout=1 cycles between each stop and the next start. No gap after the final packet. Total busy = 55+8 = 63 cycles.
